pipeline_arbiter: RTL and testbench
===================================

PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of request, pipeline and response data.
REQ-002 The block SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports req0_data / req1_data  input  DATA_W: requester payloads.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1: requester offers a payload.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1: payload accepted this cycle (combinational grant).
REQ-007 The block SHALL have port flush_req  input  1: request to flush the pipeline.
REQ-008 The block SHALL have ports pipe_inputs  output  DATA_W and pipe_in_valid  output  1: issue to pipeline stage 1.
REQ-009 The block SHALL have ports pipe_flush  output  1 and pipe_stall  output  1: global pipeline controls.
REQ-010 The block SHALL have ports pipe_outputs  input  DATA_W and pipe_out_valid  input  1: pipeline stage-3 result (pipe_out_valid unused for qualification).
REQ-011 The block SHALL have ports rsp_data  output  DATA_W, rsp_valid  output  1, rsp_id  output  1, and rsp_ready  input  1: response channel with requester tag.
REQ-012 The block SHALL have ports inflight  output  2: count of valid shadow stages (0-3), and busy  output  1: inflight!=0 or flush wave active.

Function
REQ-013 The block SHALL keep a 3-stage shadow chain (valid bit + 1-bit id per stage) mirroring the 3-stage pipeline, timed identically.
REQ-014 The block SHALL drive pipe_stall = shadow3_valid & ~rsp_ready (combinational).
REQ-015 The block SHALL drive rsp_valid = shadow3_valid, rsp_id = shadow3_id, rsp_data = pipe_outputs; a response completes when rsp_valid & rsp_ready.
REQ-016 The block SHALL register pipe_flush <= flush_req every cycle, so one flush_req cycle yields one pipe_flush cycle one clock later; back-to-back requests yield back-to-back pulses.
REQ-017 The block SHALL run a flush wave: shadow1 cleared at the edge sampling pipe_flush=1, shadow2 cleared one edge later, shadow3 cleared two edges later.
REQ-018 Per shadow stage, the clear from the flush wave SHALL take priority over stall, and stall over advance; on advance shadow1 loads the issue, shadow2 loads shadow1, shadow3 loads shadow2.
REQ-019 A grant SHALL be allowed only when pipe_stall=0 and pipe_flush=0; otherwise req0_ready = req1_ready = 0 and pipe_in_valid = 0.
REQ-020 With one requester valid, that requester SHALL be granted; with both valid, the one not granted most recently SHALL win (round-robin); after reset req0 has priority.
REQ-021 The round-robin pointer SHALL update only on an actual grant.
REQ-022 On a grant, pipe_inputs SHALL equal the granted payload and pipe_in_valid = 1; with no grant, pipe_inputs = 0 and pipe_in_valid = 0.
REQ-023 A flush_req in the same cycle as a grant SHALL not block that grant; the issued item is removed by the following flush wave.
REQ-024 inflight SHALL equal the number of set shadow valids, updated with the shadow chain.

Reset
REQ-025 While reset is high, the block SHALL hold all shadow valids and ids at 0, pipe_flush=0, flush wave idle, and round-robin pointer favouring req0.
REQ-026 Consequently, during reset, rsp_valid=0, pipe_stall=0, inflight=0, and busy=0; ready/pipe_in_valid follow REQ-019/020 combinationally from inputs.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight tags immediately, without producing any response.

Verification
REQ-028 The bench SHALL drive req0 only, data 0x11,0x22,0x33 on consecutive cycles with rsp_ready=1 -> rsp_valid with id 0 and data 0x11,0x22,0x33, each 3 cycles after issue.
REQ-029 The bench SHALL hold req0 and req1 both valid for 4 cycles -> grants alternate 0,1,0,1, and rsp_id sequence 0,1,0,1.
REQ-030 The bench SHALL fill the pipe, then drop rsp_ready for 2 cycles -> pipe_stall=1, both readys=0, rsp_data held, no response lost, and inflight stays 3.
REQ-031 The bench SHALL pulse flush_req for one cycle with 3 items in flight -> pipe_flush high one cycle later; no rsp_valid for flushed items; inflight reaches 0; an item issued the cycle after pipe_flush returns normally.
REQ-032 The bench SHALL apply flush while rsp_ready=0 (stalled) -> the flush clears stages despite the stall, and rsp_valid drops when shadow3 clears.
REQ-033 The bench SHALL assert reset with 2 items in flight -> inflight=0 and rsp_valid=0 immediately, and the first grant after release goes to req0.

Source files
------------

// File: rtl/pipeline_arbiter_if.sv
// Bundles the requester, pipeline-control and response signals of pipeline_arbiter.
// slave is the arbiter side; master is the requester/pipeline/consumer side.
interface pipeline_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] req0_data;
    logic [DATA_W-1:0] req1_data;
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic              flush_req;
    logic [DATA_W-1:0] pipe_inputs;
    logic              pipe_in_valid;
    logic              pipe_flush;
    logic              pipe_stall;
    logic [DATA_W-1:0] pipe_outputs;
    logic              pipe_out_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_id;
    logic              rsp_ready;
    logic [1:0]        inflight;
    logic              busy;

    modport slave (
        input  req0_data, req1_data, req0_valid, req1_valid, flush_req,
        input  pipe_outputs, pipe_out_valid, rsp_ready,
        output req0_ready, req1_ready, pipe_inputs, pipe_in_valid,
        output pipe_flush, pipe_stall, rsp_data, rsp_valid, rsp_id,
        output inflight, busy
    );

    modport master (
        output req0_data, req1_data, req0_valid, req1_valid, flush_req,
        output pipe_outputs, pipe_out_valid, rsp_ready,
        input  req0_ready, req1_ready, pipe_inputs, pipe_in_valid,
        input  pipe_flush, pipe_stall, rsp_data, rsp_valid, rsp_id,
        input  inflight, busy
    );
endinterface

// File: rtl/pipeline_arbiter.sv
// Round-robin two-requester issue arbiter for a 3-stage pipeline; a shadow chain of
// valid/id bits tracks in-flight items so responses can be tagged, stalled and flushed.
module pipeline_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               reset,
    pipeline_arbiter_if.slave bus
);
    logic [2:0] vld_q, vld_d;
    logic [2:0] id_q, id_d;
    logic       flush_q;
    logic       fw2_q;
    logic       fw3_q;
    logic       rr_q, rr_d;   // 1: req1 wins the next contention
    logic       stall;
    logic       grant_ok;
    logic       gnt0, gnt1;
    logic       issue_vld;
    logic       issue_id;
    logic [2:0] upstream_vld;
    logic [2:0] upstream_id;
    logic [2:0] clr;
    logic       unused_pipe_out_valid;

    assign unused_pipe_out_valid = bus.pipe_out_valid;

    assign stall    = vld_q[2] & ~bus.rsp_ready;
    assign grant_ok = ~stall & ~flush_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (grant_ok) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
                gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign issue_vld = gnt0 | gnt1;
    assign issue_id  = gnt1;

    always_comb begin
        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
    end

    // The flush wave reaches stage k one edge after stage k-1; per stage clear beats stall beats advance.
    always_comb begin
        upstream_vld = {vld_q[1:0], issue_vld};
        upstream_id  = {id_q[1:0], issue_id};
        clr          = {fw3_q, fw2_q, flush_q};
        vld_d        = vld_q;
        id_d         = id_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (clr[i]) begin
                vld_d[i] = 1'b0;
                id_d[i]  = 1'b0;
            end else if (!stall) begin
                vld_d[i] = upstream_vld[i];
                id_d[i]  = upstream_id[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            id_q    <= '0;
            flush_q <= 1'b0;
            fw2_q   <= 1'b0;
            fw3_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            id_q    <= id_d;
            flush_q <= bus.flush_req;
            fw2_q   <= flush_q;
            fw3_q   <= fw2_q;
            rr_q    <= rr_d;
        end
    end

    assign bus.req0_ready    = gnt0;
    assign bus.req1_ready    = gnt1;
    assign bus.pipe_in_valid = issue_vld;
    assign bus.pipe_inputs   = gnt0 ? bus.req0_data : (gnt1 ? bus.req1_data : '0);
    assign bus.pipe_flush    = flush_q;
    assign bus.pipe_stall    = stall;
    assign bus.rsp_valid     = vld_q[2];
    assign bus.rsp_id        = id_q[2];
    assign bus.rsp_data      = bus.pipe_outputs;
    assign bus.inflight      = 2'(vld_q[0]) + 2'(vld_q[1]) + 2'(vld_q[2]);
    assign bus.busy          = (bus.inflight != 2'd0) | flush_q | fw2_q | fw3_q;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed self-checking bench for pipeline_arbiter, with a small 3-stage data pipeline
// behind it that advances whenever pipe_stall is low.
module tb_pipeline_arbiter;
    logic clk;
    logic reset;
    int   n_err;
    int   n_chk;

    pipeline_arbiter_if #(.DATA_W(32)) bus ();

    pipeline_arbiter #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] st1, st2, st3;
    logic [2:0]  stv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st1 <= '0;
            st2 <= '0;
            st3 <= '0;
            stv <= '0;
        end else if (!bus.pipe_stall) begin
            st1 <= bus.pipe_inputs;
            st2 <= st1;
            st3 <= st2;
            stv <= {stv[1:0], bus.pipe_in_valid};
        end
    end

    assign bus.pipe_outputs   = st3;
    assign bus.pipe_out_valid = stv[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        bus.flush_req  = 1'b0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues base+1..base+3 from req0 on three consecutive cycles.
    task automatic issue3(input logic [31:0] base);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1;
            bus.req0_data  = base + 32'(i) + 32'd1;
            #1;
            check("issue_rdy0", 32'(bus.req0_ready), 32'd1);
            check("issue_data", bus.pipe_inputs, base + 32'(i) + 32'd1);
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        reset = 1'b1;
        idle_inputs();

        // Reset state, with combinational grant still visible.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_stall", 32'(bus.pipe_stall), 32'd0);
        check("rst_inflight", 32'(bus.inflight), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_flush", 32'(bus.pipe_flush), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 32'h5A;
        bus.req1_data  = 32'hA5;
        #1;
        check("rst_rdy0", 32'(bus.req0_ready), 32'd1);
        check("rst_rdy1", 32'(bus.req1_ready), 32'd0);
        check("rst_pin", bus.pipe_inputs, 32'h5A);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        // Single requester stream: responses 3 cycles after issue.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1;
            bus.req0_data  = 32'h11 * 32'(i + 1);
            #1;
            check("s1_rdy0", 32'(bus.req0_ready), 32'd1);
            check("s1_piv", 32'(bus.pipe_in_valid), 32'd1);
            check("s1_pin", bus.pipe_inputs, 32'h11 * 32'(i + 1));
            check("s1_inflight", 32'(bus.inflight), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
            #1;
            check("s1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("s1_rsp_data", bus.rsp_data, 32'h11 * 32'(i + 1));
            check("s1_rsp_id", 32'(bus.rsp_id), 32'd0);
            check("s1_inflight_drain", 32'(bus.inflight), 32'(3 - i));
        end
        @(negedge clk);
        #1;
        check("s1_rsp_end", 32'(bus.rsp_valid), 32'd0);
        check("s1_inflight_end", 32'(bus.inflight), 32'd0);

        // Contention: alternate grants starting with req0, tagged responses follow.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req0_valid = (i < 4);
            bus.req1_valid = (i < 4);
            bus.req0_data  = 32'hA0 + 32'(i);
            bus.req1_data  = 32'hB0 + 32'(i);
            #1;
            if (i < 4) begin
                check("rr_rdy0", 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_rdy1", 32'(bus.req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
                check("rr_pin", bus.pipe_inputs, (i % 2 == 0) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i));
            end
            if (i >= 3 && i < 7) begin
                check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(bus.rsp_id), 32'((i - 3) % 2));
                check("rr_rsp_data", bus.rsp_data,
                      ((i - 3) % 2 == 0) ? 32'hA0 + 32'(i - 3) : 32'hB0 + 32'(i - 3));
            end
            if (i == 7) check("rr_rsp_end", 32'(bus.rsp_valid), 32'd0);
        end

        // Back-pressure: full pipe held for two cycles, nothing lost.
        issue3(32'h50);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.rsp_ready  = 1'b0;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req0_data  = 32'h54;
            bus.req1_data  = 32'h55;
            #1;
            check("st_stall", 32'(bus.pipe_stall), 32'd1);
            check("st_rdy0", 32'(bus.req0_ready), 32'd0);
            check("st_rdy1", 32'(bus.req1_ready), 32'd0);
            check("st_piv", 32'(bus.pipe_in_valid), 32'd0);
            check("st_pin", bus.pipe_inputs, 32'd0);
            check("st_rsp_data", bus.rsp_data, 32'h51);
            check("st_inflight", 32'(bus.inflight), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check("st_stall_off", 32'(bus.pipe_stall), 32'd0);
            check("st_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("st_rsp_drain", bus.rsp_data, 32'h51 + 32'(i));
        end
        @(negedge clk);
        #1;
        check("st_rsp_end", 32'(bus.rsp_valid), 32'd0);

        // Flush pulse with three in flight, then a fresh item after the pulse.
        issue3(32'h60);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.flush_req  = 1'b1;
        #1;
        check("fl_pflush_pre", 32'(bus.pipe_flush), 32'd0);
        check("fl_rsp0", bus.rsp_data, 32'h61);
        check("fl_inflight3", 32'(bus.inflight), 32'd3);
        @(negedge clk);
        bus.flush_req  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h99;
        #1;
        check("fl_pflush", 32'(bus.pipe_flush), 32'd1);
        check("fl_rdy0_blk", 32'(bus.req0_ready), 32'd0);
        check("fl_piv_blk", 32'(bus.pipe_in_valid), 32'd0);
        check("fl_rsp1", bus.rsp_data, 32'h62);
        check("fl_inflight2", 32'(bus.inflight), 32'd2);
        check("fl_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.req0_data = 32'h71;
        #1;
        check("fl_pflush_off", 32'(bus.pipe_flush), 32'd0);
        check("fl_rdy0_after", 32'(bus.req0_ready), 32'd1);
        check("fl_pin_after", bus.pipe_inputs, 32'h71);
        check("fl_rsp2", bus.rsp_data, 32'h63);
        check("fl_inflight1", 32'(bus.inflight), 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check("fl_rsp_gap", 32'(bus.rsp_valid), 32'd0);
        check("fl_busy_wave", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        check("fl_rsp_gap2", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("fl_new_valid", 32'(bus.rsp_valid), 32'd1);
        check("fl_new_data", bus.rsp_data, 32'h71);
        check("fl_new_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        #1;
        check("fl_inflight0", 32'(bus.inflight), 32'd0);
        check("fl_busy_idle", 32'(bus.busy), 32'd0);

        // Flush while stalled: stages clear one per edge, rsp_valid drops with stage 3.
        issue3(32'h80);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.flush_req  = 1'b1;
        #1;
        check("sf_stall", 32'(bus.pipe_stall), 32'd1);
        check("sf_rsp", bus.rsp_data, 32'h81);
        @(negedge clk);
        bus.flush_req = 1'b0;
        #1;
        check("sf_pflush", 32'(bus.pipe_flush), 32'd1);
        check("sf_inflight3", 32'(bus.inflight), 32'd3);
        @(negedge clk);
        #1;
        check("sf_inflight2", 32'(bus.inflight), 32'd2);
        check("sf_rsp_hold", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        check("sf_inflight1", 32'(bus.inflight), 32'd1);
        check("sf_rsp_data_hold", bus.rsp_data, 32'h81);
        @(negedge clk);
        #1;
        check("sf_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("sf_inflight0", 32'(bus.inflight), 32'd0);
        check("sf_stall_off", 32'(bus.pipe_stall), 32'd0);
        check("sf_busy", 32'(bus.busy), 32'd0);
        bus.rsp_ready = 1'b1;

        // Reset mid-flight: tags vanish, first grant afterwards goes to req0.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1;
            bus.req0_data  = 32'h91 + 32'(i);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check("mr_inflight2", 32'(bus.inflight), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mr_inflight0", 32'(bus.inflight), 32'd0);
        check("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 32'hC0;
        bus.req1_data  = 32'hD0;
        #1;
        check("mr_rdy0_in_rst", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_first_rdy0", 32'(bus.req0_ready), 32'd1);
        check("mr_first_pin", bus.pipe_inputs, 32'hC0);
        @(negedge clk);
        #1;
        check("mr_second_rdy1", 32'(bus.req1_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mr_no_stale", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("mr_rsp_c0", bus.rsp_data, 32'hC0);
        check("mr_rsp_id0", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        #1;
        check("mr_rsp_d0", bus.rsp_data, 32'hD0);
        check("mr_rsp_id1", 32'(bus.rsp_id), 32'd1);
        @(negedge clk);
        #1;
        check("mr_rsp_end", 32'(bus.rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
